// File: rtl/game_pkg.sv
// Shared constants and state encoding for the memory-game controller.
package game_pkg;

  // Width of round and level values.
  localparam int P_DATA    = 4;
  // Default number of 1 Hz ticks without a key press before the player loses.
  localparam int P_TIMEOUT = 5;
  // Default width of the timeout counter (must hold P_TIMEOUT-1).
  localparam int P_TMR_W   = 3;

  // FSM state codes; the numeric values are visible on the state output.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PLAY      = 3'd2,
    S_WAIT_USER = 3'd3,
    S_CHECK     = 3'd4,
    S_NEXT      = 3'd5,
    S_WIN       = 3'd6,
    S_LOSE      = 3'd7
  } state_e;

  // Effective number of rounds: a level of zero plays a single round.
  function automatic logic [P_DATA-1:0] eff_level(input logic [P_DATA-1:0] lvl);
    return (lvl == '0) ? P_DATA'(1) : lvl;
  endfunction

endpackage

// File: rtl/game_timeout_tmr.sv
// Input-timeout counter: counts qualified 1 Hz ticks, cleared on demand,
// and flags when the next tick would be the last one allowed.
module game_timeout_tmr #(
  parameter int P_TIMEOUT = 5,
  parameter int P_TMR_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [P_TMR_W-1:0] LP_LAST = P_TMR_W'(P_TIMEOUT - 1);

  logic [P_TMR_W-1:0] cnt_q;
  logic [P_TMR_W-1:0] cnt_d;

  // Expire is a level: the FSM combines it with the tick to decide LOSE.
  assign expire_o = (cnt_q == LP_LAST);

  // Next count: clear wins over increment; saturate at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expire_o) begin
      cnt_d = cnt_q + P_TMR_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Memory-game round sequencer. Starts a match, paces the display counter,
// gates user keys into the entry counter, enforces an input timeout and
// declares WIN/LOSE.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for enter
// SETUP      | latch target round count, reset round to 0
// PLAY       | sequence display running, paced by tick_1hz
// WAIT_USER  | accepting user keys, timeout active
// CHECK      | decide whether the last round has been completed
// NEXT       | advance round, clear both counters
// WIN        | match won, waiting for enter
// LOSE       | wrong key or timeout, waiting for enter
module game_round_ctrl #(
  parameter int P_DATA    = game_pkg::P_DATA,
  parameter int P_TIMEOUT = game_pkg::P_TIMEOUT,
  parameter int P_TMR_W   = game_pkg::P_TMR_W
) (
  input  logic              clk,
  input  logic              R,
  input  logic              enter,
  input  logic [P_DATA-1:0] level,
  input  logic              tick_1hz,
  input  logic              key_valid,
  input  logic              key_match,
  input  logic              seq_tc,
  input  logic              user_tc,
  output logic              en_seq,
  output logic              en_user,
  output logic              clr_seq,
  output logic              clr_user,
  output logic [P_DATA-1:0] round,
  output logic [2:0]        state,
  output logic              win,
  output logic              lose
);

  import game_pkg::*;

  state_e            state_q;
  logic [P_DATA-1:0] round_q;
  logic [P_DATA-1:0] target_q;
  logic              clr_seq_q;
  logic              clr_user_q;
  logic              win_q;
  logic              lose_q;

  logic in_play;
  logic in_wait;
  logic key_ok;
  logic key_bad;
  logic tmr_clr;
  logic tmr_inc;
  logic tmr_expire;
  logic last_round;

  assign in_play    = (state_q == S_PLAY);
  assign in_wait    = (state_q == S_WAIT_USER);
  assign key_ok     = key_valid && key_match;
  assign key_bad    = key_valid && !key_match;
  assign last_round = (round_q == (target_q - P_DATA'(1)));

  // The timer restarts when the user phase begins and on every correct key;
  // it only advances on ticks that no higher-priority event pre-empts.
  assign tmr_clr = (in_play && seq_tc) || (in_wait && key_ok);
  assign tmr_inc = in_wait && !key_valid && !user_tc && tick_1hz;

  game_timeout_tmr #(
    .P_TIMEOUT (P_TIMEOUT),
    .P_TMR_W   (P_TMR_W)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (R),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .expire_o (tmr_expire)
  );

  // Counter enables are combinational so the counters see the same-cycle strobe.
  assign en_seq  = in_play && tick_1hz;
  assign en_user = in_wait && key_ok;

  assign clr_seq  = clr_seq_q;
  assign clr_user = clr_user_q;
  assign round    = round_q;
  assign state    = state_q;
  assign win      = win_q;
  assign lose     = lose_q;

  // Main FSM with registered clear pulses and result flags.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= S_IDLE;
      round_q    <= '0;
      target_q   <= '0;
      clr_seq_q  <= 1'b0;
      clr_user_q <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      clr_seq_q  <= 1'b0;
      clr_user_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enter) begin
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          target_q   <= eff_level(level);
          round_q    <= '0;
          clr_seq_q  <= 1'b1;
          clr_user_q <= 1'b1;
          state_q    <= S_PLAY;
        end
        S_PLAY: begin
          if (seq_tc) begin
            clr_user_q <= 1'b1;
            state_q    <= S_WAIT_USER;
          end
        end
        S_WAIT_USER: begin
          if (key_bad) begin
            lose_q  <= 1'b1;
            state_q <= S_LOSE;
          end else if (key_ok) begin
            state_q <= S_WAIT_USER;
          end else if (user_tc) begin
            state_q <= S_CHECK;
          end else if (tick_1hz && tmr_expire) begin
            lose_q  <= 1'b1;
            state_q <= S_LOSE;
          end
        end
        S_CHECK: begin
          if (last_round) begin
            win_q   <= 1'b1;
            state_q <= S_WIN;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          // target is at most 15, so round tops out at 14 and cannot wrap.
          round_q    <= round_q + P_DATA'(1);
          clr_seq_q  <= 1'b1;
          clr_user_q <= 1'b1;
          state_q    <= S_PLAY;
        end
        S_WIN: begin
          if (enter) begin
            win_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_LOSE: begin
          if (enter) begin
            lose_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with hand-computed expectations.
module tb_game_round_ctrl;

  logic       clk;
  logic       R;
  logic       enter;
  logic [3:0] level;
  logic       tick_1hz;
  logic       key_valid;
  logic       key_match;
  logic       seq_tc;
  logic       user_tc;
  logic       en_seq;
  logic       en_user;
  logic       clr_seq;
  logic       clr_user;
  logic [3:0] round;
  logic [2:0] state;
  logic       win;
  logic       lose;

  int tests = 0;
  int fails = 0;

  game_round_ctrl #(.P_DATA(4), .P_TIMEOUT(5), .P_TMR_W(3)) dut (
    .clk       (clk),
    .R         (R),
    .enter     (enter),
    .level     (level),
    .tick_1hz  (tick_1hz),
    .key_valid (key_valid),
    .key_match (key_match),
    .seq_tc    (seq_tc),
    .user_tc   (user_tc),
    .en_seq    (en_seq),
    .en_user   (en_user),
    .clr_seq   (clr_seq),
    .clr_user  (clr_user),
    .round     (round),
    .state     (state),
    .win       (win),
    .lose      (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_enter();
    enter = 1'b1; clk1(); enter = 1'b0;
  endtask

  task automatic pulse_seq_tc();
    seq_tc = 1'b1; clk1(); seq_tc = 1'b0;
  endtask

  task automatic pulse_user_tc();
    user_tc = 1'b1; clk1(); user_tc = 1'b0;
  endtask

  task automatic key_ok();
    key_valid = 1'b1; key_match = 1'b1; clk1();
    key_valid = 1'b0; key_match = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; clk1(); tick_1hz = 1'b0; clk1();
    end
  endtask

  // From IDLE: SETUP, PLAY, then display done -> WAIT_USER.
  task automatic go_wait(input string tag);
    pulse_enter();
    clk1();
    pulse_seq_tc();
    chk(tag, {29'd0, state}, 32'd3);
  endtask

  initial begin
    R = 1'b0; enter = 1'b0; level = 4'd2; tick_1hz = 1'b0;
    key_valid = 1'b0; key_match = 1'b0; seq_tc = 1'b0; user_tc = 1'b0;
    #2;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_round", {28'd0, round}, 32'd0);
    chk("rst_flags", {28'd0, win, lose, clr_seq, clr_user}, 32'd0);
    chk("rst_en", {30'd0, en_seq, en_user}, 32'd0);
    clk1(); clk1();
    R = 1'b1;
    clk1();

    // Full win at level 2.
    pulse_enter();
    chk("win_setup", {29'd0, state}, 32'd1);
    chk("win_setup_clr", {30'd0, clr_seq, clr_user}, 32'd0);
    clk1();
    chk("win_play", {29'd0, state}, 32'd2);
    chk("win_play_clr", {30'd0, clr_seq, clr_user}, 32'd3);
    clk1();
    chk("win_clr_pulse_end", {30'd0, clr_seq, clr_user}, 32'd0);
    tick_1hz = 1'b1; #1;
    chk("play_en_seq", {31'd0, en_seq}, 32'd1);
    clk1(); tick_1hz = 1'b0;
    enter = 1'b1; key_valid = 1'b1; key_match = 1'b1; #1;
    chk("play_ign_en_user", {31'd0, en_user}, 32'd0);
    clk1();
    enter = 1'b0; key_valid = 1'b0; key_match = 1'b0;
    chk("play_ign_state", {29'd0, state}, 32'd2);
    pulse_seq_tc();
    chk("r0_wait", {29'd0, state}, 32'd3);
    chk("r0_wait_clr", {30'd0, clr_seq, clr_user}, 32'd1);
    key_valid = 1'b1; key_match = 1'b1; #1;
    chk("r0_en_user", {31'd0, en_user}, 32'd1);
    clk1(); key_valid = 1'b0; key_match = 1'b0;
    chk("r0_after_key", {29'd0, state}, 32'd3);
    pulse_user_tc();
    chk("r0_check", {29'd0, state}, 32'd4);
    clk1();
    chk("r0_next", {29'd0, state}, 32'd5);
    clk1();
    chk("r1_play", {29'd0, state}, 32'd2);
    chk("r1_round", {28'd0, round}, 32'd1);
    chk("r1_clr", {30'd0, clr_seq, clr_user}, 32'd3);
    pulse_seq_tc();
    key_ok(); key_ok();
    pulse_user_tc();
    chk("r1_check", {29'd0, state}, 32'd4);
    clk1();
    chk("win_state", {29'd0, state}, 32'd6);
    chk("win_flags", {30'd0, win, lose}, 32'd2);
    chk("win_round", {28'd0, round}, 32'd1);
    clk1();
    chk("win_hold", {29'd0, state}, 32'd6);
    pulse_enter();
    chk("win_exit_state", {29'd0, state}, 32'd0);
    chk("win_exit_flags", {30'd0, win, lose}, 32'd0);
    chk("win_exit_round", {28'd0, round}, 32'd1);

    // Wrong key.
    go_wait("wk_wait");
    chk("wk_round_cleared", {28'd0, round}, 32'd0);
    key_valid = 1'b1; key_match = 1'b0; #1;
    chk("wk_en_user", {31'd0, en_user}, 32'd0);
    clk1(); key_valid = 1'b0;
    chk("wk_lose", {29'd0, state}, 32'd7);
    chk("wk_flags", {30'd0, win, lose}, 32'd1);
    pulse_enter();
    chk("wk_exit", {29'd0, state}, 32'd0);
    chk("wk_exit_lose", {31'd0, lose}, 32'd0);

    // Timeout after five ticks.
    go_wait("to_wait");
    ticks(4);
    chk("to_4ticks", {29'd0, state}, 32'd3);
    tick_1hz = 1'b1; clk1(); tick_1hz = 1'b0;
    chk("to_5th_lose", {29'd0, state}, 32'd7);
    chk("to_lose_flag", {31'd0, lose}, 32'd1);
    pulse_enter();

    // Key (coinciding with a tick) restarts the timeout.
    go_wait("tr_wait");
    ticks(4);
    key_valid = 1'b1; key_match = 1'b1; tick_1hz = 1'b1; #1;
    chk("tr_key_tick_en_user", {31'd0, en_user}, 32'd1);
    clk1();
    key_valid = 1'b0; key_match = 1'b0; tick_1hz = 1'b0;
    chk("tr_key_tick_state", {29'd0, state}, 32'd3);
    ticks(4);
    chk("tr_4more", {29'd0, state}, 32'd3);
    tick_1hz = 1'b1; clk1(); tick_1hz = 1'b0;
    chk("tr_5th_lose", {29'd0, state}, 32'd7);
    pulse_enter();

    // Level 0 plays one round; also seq_tc together with a tick.
    level = 4'd0;
    pulse_enter();
    clk1();
    seq_tc = 1'b1; tick_1hz = 1'b1; #1;
    chk("l0_seq_tick_en_seq", {31'd0, en_seq}, 32'd1);
    clk1(); seq_tc = 1'b0; tick_1hz = 1'b0;
    chk("l0_wait", {29'd0, state}, 32'd3);
    key_ok();
    pulse_user_tc();
    chk("l0_check", {29'd0, state}, 32'd4);
    clk1();
    chk("l0_win", {29'd0, state}, 32'd6);
    chk("l0_round", {28'd0, round}, 32'd0);
    chk("l0_win_flag", {31'd0, win}, 32'd1);
    pulse_enter();

    // Asynchronous reset in PLAY of round 1.
    level = 4'd3;
    go_wait("ar_wait");
    key_ok();
    pulse_user_tc();
    clk1(); clk1();
    chk("ar_play_r1", {25'd0, state, round}, {25'd0, 3'd2, 4'd1});
    #2; R = 1'b0; #1;
    chk("ar_state", {29'd0, state}, 32'd0);
    chk("ar_round", {28'd0, round}, 32'd0);
    chk("ar_flags", {30'd0, win, lose}, 32'd0);
    clk1();
    R = 1'b1;
    pulse_enter();
    chk("ar_setup", {29'd0, state}, 32'd1);
    clk1();
    chk("ar_play", {29'd0, state}, 32'd2);
    chk("ar_clr", {30'd0, clr_seq, clr_user}, 32'd3);
    clk1();
    chk("ar_clr_end", {30'd0, clr_seq, clr_user}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
